// File: rtl/mmu_pte_fetch_responder.sv
// mmu_pte_fetch_responder
//   Responder end of the page-table-walker PTE fetch path. Takes one PTE
//   address request at a time, reads the 32-bit PTE through a synchronous
//   memory/dcache read port, and hands the PTE back to the walker. Any fetch
//   that cannot produce a real PTE (misaligned address, bus error, timeout)
//   returns 32'h0, so the walker sees V=0 and raises a page fault.
//
// Ports
//   clk, rst             single clock, synchronous active-high reset
//   i_ptw_rsp_drive_1    request pulse from the walker
//   i_ptw_rsp_data_48    {l1Way[47:44], reqIndex[43:38], pteAddr[37:4],
//                         cpuMode[3:2], reqType[1:0]}
//   o_rsp_ptw_free_1     pulse one cycle after a request is captured
//   o_rsp_mem_valid_1    memory read request valid
//   i_mem_rsp_ready_1    memory accepts the read when valid && ready
//   o_rsp_mem_addr_34    word-aligned PTE byte address
//   i_mem_rsp_valid_1    read data valid (single cycle)
//   i_mem_rsp_data_32    read data
//   i_mem_rsp_err_1      bus error, qualified by i_mem_rsp_valid_1
//   o_rsp_ptw_drive_1    pulse: PTE is available on o_rsp_ptw_data_32
//   o_rsp_ptw_data_32    returned PTE, stable from drive pulse to free pulse
//   i_ptw_rsp_free_1     pulse: walker consumed the PTE
//   o_proto_err_1        sticky: request arrived while busy (cleared by rst)
//
// Handshakes
//   Memory side is valid/ready: valid and address stay constant until the
//   cycle in which valid && ready, which is the single transfer. Walker side
//   uses one-cycle pulses in both directions; a pulse arriving in a state
//   that does not expect it is ignored (a busy-time request is dropped and
//   flagged on o_proto_err_1).
module mmu_pte_fetch_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ptw_rsp_drive_1,
  input  logic [47:0] i_ptw_rsp_data_48,
  output logic        o_rsp_ptw_free_1,
  output logic        o_rsp_mem_valid_1,
  input  logic        i_mem_rsp_ready_1,
  output logic [33:0] o_rsp_mem_addr_34,
  input  logic        i_mem_rsp_valid_1,
  input  logic [31:0] i_mem_rsp_data_32,
  input  logic        i_mem_rsp_err_1,
  output logic        o_rsp_ptw_drive_1,
  output logic [31:0] o_rsp_ptw_data_32,
  input  logic        i_ptw_rsp_free_1,
  output logic        o_proto_err_1
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_RESP = 3'd3,
    S_HOLD = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [33:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             free_q, free_d;
  logic             proto_err_q, proto_err_d;

  logic [33:0]      req_addr;
  logic             unused_req_fields;

  assign req_addr = i_ptw_rsp_data_48[37:4];
  // Way, index, mode and type travel with the walker's own bookkeeping;
  // the responder only needs the address.
  assign unused_req_fields = ^{i_ptw_rsp_data_48[47:38], i_ptw_rsp_data_48[3:0]};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    free_d      = 1'b0;
    proto_err_d = proto_err_q | (i_ptw_rsp_drive_1 && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (i_ptw_rsp_drive_1) begin
          addr_d = req_addr;
          free_d = 1'b1;
          if (req_addr[1:0] != 2'b00) begin
            // A misaligned PTE address never touches memory.
            data_d  = 32'h0;
            state_d = S_RESP;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (i_mem_rsp_ready_1) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Data is checked before the timeout so a response landing in the
        // last allowed cycle is still delivered.
        if (i_mem_rsp_valid_1) begin
          data_d  = i_mem_rsp_err_1 ? 32'h0 : i_mem_rsp_data_32;
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          data_d  = 32'h0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (i_ptw_rsp_free_1) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      free_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      free_q      <= free_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign o_rsp_ptw_free_1  = free_q;
  assign o_rsp_mem_valid_1 = (state_q == S_REQ);
  assign o_rsp_mem_addr_34 = addr_q;
  assign o_rsp_ptw_drive_1 = (state_q == S_RESP);
  assign o_rsp_ptw_data_32 = data_q;
  assign o_proto_err_1     = proto_err_q;

endmodule

// File: tb/tb_mmu_pte_fetch_responder.sv
// Testbench for mmu_pte_fetch_responder. Inputs are driven and outputs are
// sampled on the falling edge. Cycle n of a transaction is the n-th falling
// edge after the one that raised the request pulse.
module tb_mmu_pte_fetch_responder;

  localparam int T = 8;

  logic        clk;
  logic        rst;
  logic        i_drive;
  logic [47:0] i_data48;
  logic        o_free;
  logic        o_mem_valid;
  logic        i_ready;
  logic [33:0] o_mem_addr;
  logic        i_mem_valid;
  logic [31:0] i_mem_data;
  logic        i_mem_err;
  logic        o_drive;
  logic [31:0] o_data;
  logic        i_free;
  logic        o_proto_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  bit          proto_model = 1'b0;

  mmu_pte_fetch_responder #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_ptw_rsp_drive_1 (i_drive),
    .i_ptw_rsp_data_48 (i_data48),
    .o_rsp_ptw_free_1  (o_free),
    .o_rsp_mem_valid_1 (o_mem_valid),
    .i_mem_rsp_ready_1 (i_ready),
    .o_rsp_mem_addr_34 (o_mem_addr),
    .i_mem_rsp_valid_1 (i_mem_valid),
    .i_mem_rsp_data_32 (i_mem_data),
    .i_mem_rsp_err_1   (i_mem_err),
    .o_rsp_ptw_drive_1 (o_drive),
    .o_rsp_ptw_data_32 (o_data),
    .i_ptw_rsp_free_1  (i_free),
    .o_proto_err_1     (o_proto_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One walker request with a scripted memory side. The model decides the
  // returned PTE and the cycle of the drive pulse from the scenario alone:
  //   misaligned                     -> PTE 0, drive in cycle 1
  //   response r cycles after the
  //   handshake, 1 <= r <= T         -> data (or 0 on error), drive at hs+r+1
  //   no response within T cycles    -> PTE 0, drive at hs+T+1
  task automatic run_txn(input logic [33:0] addr, input int rdy_dly, input int rsp_dly,
                         input bit give_rsp, input bit rsp_err, input logic [31:0] rsp_data,
                         input bit proto_poke, input bit noise, input bit stray_free);
    int          n_h, exp_n, drive_n, drive_cnt, free_cnt, valid_cnt, addr_bad, hs_cnt, hold_len;
    bit          aligned;
    bit          free_at1;
    logic [31:0] exp_pte, got, sb;
    aligned   = (addr[1:0] == 2'b00);
    n_h       = 1 + rdy_dly;
    if (!aligned) begin
      exp_pte = 32'h0;
      exp_n   = 1;
    end else if (give_rsp && rsp_dly >= 1 && rsp_dly <= T) begin
      exp_pte = rsp_err ? 32'h0 : rsp_data;
      exp_n   = n_h + rsp_dly + 1;
    end else begin
      exp_pte = 32'h0;
      exp_n   = n_h + T + 1;
    end
    exp_q.push_back(exp_pte);
    if (proto_poke) proto_model = 1'b1;

    drive_n = -1; drive_cnt = 0; free_cnt = 0; valid_cnt = 0; addr_bad = 0; hs_cnt = 0;
    free_at1 = 1'b0; got = 32'h0;

    @(negedge clk);
    i_free      = 1'b0;
    i_drive     = 1'b1;
    i_data48    = {4'($urandom), 6'($urandom), addr, 2'($urandom), 2'($urandom)};
    i_ready     = 1'b0;
    i_mem_valid = 1'b0;
    i_mem_err   = 1'b0;

    for (int n = 1; n <= exp_n + 2; n++) begin
      @(negedge clk);
      // observe
      if (o_free) begin
        free_cnt++;
        if (n == 1) free_at1 = 1'b1;
      end
      if (o_mem_valid) begin
        valid_cnt++;
        if (o_mem_addr !== addr) addr_bad++;
      end
      if (o_drive) begin
        drive_cnt++;
        if (drive_n < 0) begin
          drive_n = n;
          got     = o_data;
        end
      end
      // drive
      i_drive     = proto_poke && (n == 2);
      i_data48    = {4'($urandom), 6'($urandom), 34'($urandom), 4'($urandom)};
      i_ready     = (n >= n_h);
      i_free      = stray_free && (n == exp_n);
      i_mem_valid = 1'b0;
      i_mem_err   = 1'b0;
      i_mem_data  = $urandom;
      if (aligned && give_rsp && n == n_h + rsp_dly) begin
        i_mem_valid = 1'b1;
        i_mem_err   = rsp_err;
        i_mem_data  = rsp_data;
      end else if (noise && n < n_h) begin
        i_mem_valid = 1'b1;
        i_mem_err   = 1'($urandom);
      end
      if (o_mem_valid && i_ready) hs_cnt++;
    end

    check("free_pulse_cycle1", {63'd0, free_at1}, 64'd1);
    check("free_pulse_count", 64'(free_cnt), 64'd1);
    check("mem_valid_cycles", 64'(valid_cnt), aligned ? 64'(n_h) : 64'd0);
    check("mem_addr_stable", 64'(addr_bad), 64'd0);
    check("mem_handshakes", 64'(hs_cnt), aligned ? 64'd1 : 64'd0);
    check("drive_pulse_count", 64'(drive_cnt), 64'd1);
    check("drive_pulse_cycle", 64'(drive_n), 64'(exp_n));
    sb = exp_q.pop_front();
    if (drive_cnt > 0) check("returned_pte", 64'(got), 64'(sb));
    check("proto_err", {63'd0, o_proto_err}, {63'd0, proto_model});

    hold_len = $urandom_range(0, 3);
    for (int k = 0; k <= hold_len; k++) begin
      @(negedge clk);
      i_drive     = 1'b0;
      i_mem_valid = 1'b0;
      i_free      = 1'b0;
      check("hold_data", 64'(o_data), 64'(exp_pte));
      check("hold_no_drive", {63'd0, o_drive}, 64'd0);
    end
    i_free = 1'b1;
  endtask

  // Reset in the middle of a fetch, then a late memory response.
  task automatic run_reset_mid();
    int drive_cnt, valid_cnt;
    drive_cnt = 0; valid_cnt = 0;
    @(negedge clk);
    i_free   = 1'b0;
    i_drive  = 1'b1;
    i_data48 = {4'h3, 6'h11, 34'h1_2345_6780, 4'h5};
    i_ready  = 1'b1;
    @(negedge clk);
    i_drive = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    proto_model = 1'b0;
    check("rst_free", {63'd0, o_free}, 64'd0);
    check("rst_mem_valid", {63'd0, o_mem_valid}, 64'd0);
    check("rst_mem_addr", 64'(o_mem_addr), 64'd0);
    check("rst_drive", {63'd0, o_drive}, 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    check("rst_proto_err", {63'd0, o_proto_err}, 64'd0);
    i_mem_valid = 1'b1;
    i_mem_err   = 1'b0;
    i_mem_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    i_mem_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (o_drive) drive_cnt++;
      if (o_mem_valid) valid_cnt++;
    end
    check("late_rsp_no_drive", 64'(drive_cnt), 64'd0);
    check("late_rsp_no_mem_valid", 64'(valid_cnt), 64'd0);
    i_ready = 1'b0;
  endtask

  initial begin
    logic [33:0] a;
    rst = 1'b1; i_drive = 1'b0; i_data48 = '0; i_ready = 1'b0;
    i_mem_valid = 1'b0; i_mem_data = '0; i_mem_err = 1'b0; i_free = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_free", {63'd0, o_free}, 64'd0);
    check("reset_mem_valid", {63'd0, o_mem_valid}, 64'd0);
    check("reset_mem_addr", 64'(o_mem_addr), 64'd0);
    check("reset_drive", {63'd0, o_drive}, 64'd0);
    check("reset_data", 64'(o_data), 64'd0);
    check("reset_proto_err", {63'd0, o_proto_err}, 64'd0);
    rst = 1'b0;

    // directed scenarios
    run_txn(34'h0_0040_1008, 0, 2, 1, 0, 32'h2000_0C01, 0, 0, 0); // aligned read
    run_txn(34'h0_0040_1008, 0, 1, 1, 0, 32'h1234_5671, 0, 0, 0); // minimum latency
    run_txn(34'h2_8000_0FFC, 5, 1, 1, 0, 32'h0000_ABCD, 0, 1, 0); // backpressure + stray mem valid
    run_txn(34'h0_1000_0004, 0, 1, 1, 1, 32'hFFFF_FFFF, 0, 0, 0); // bus error
    run_txn(34'h0_1000_0010, 0, 0, 0, 0, 32'h0,         0, 0, 0); // timeout
    run_txn(34'h0_0040_100A, 0, 1, 1, 0, 32'h5555_5555, 0, 0, 0); // misaligned
    run_txn(34'h0_2000_0020, 1, T, 1, 0, 32'hCAFE_0001, 0, 0, 1); // data in timeout cycle
    run_txn(34'h0_2000_0024, 0, T + 1, 1, 0, 32'hCAFE_0003, 0, 0, 0); // response too late
    run_txn(34'h0_3000_0100, 0, 3, 1, 0, 32'h0BAD_F00D, 1, 0, 0); // second request in flight
    run_reset_mid();

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      a = {2'($urandom_range(0, 3)), 32'($urandom)};
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      run_txn(a, $urandom_range(0, 6), $urandom_range(1, T + 2),
              ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) == 0), 32'($urandom),
              ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    i_free = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
